// File: rtl/modexp_io_sequencer_if.sv
// Word-serial bus between the host-side sequencer (master) and the ModExp core (slave).
interface modexp_io_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] m_buf;
  logic [DATA_WIDTH-1:0] e_buf;
  logic [DATA_WIDTH-1:0] n_buf;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] t_buf;
  logic [63:0]           nprime0;
  logic                  startInput;
  logic                  startCompute;
  logic                  getResult;
  logic [4:0]            exp_state;
  logic [DATA_WIDTH-1:0] res_out;

  modport master (
    output m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
    output startInput, startCompute, getResult,
    input  exp_state, res_out
  );

  modport slave (
    input  m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
    input  startInput, startCompute, getResult,
    output exp_state, res_out
  );
endinterface

// File: rtl/modexp_io_sequencer.sv
// Host-side sequencer for ModExp: latches full-width operands, streams them LSW first,
// waits for completion (with timeout) and reassembles the result words.
module modexp_io_sequencer #(
  parameter int unsigned WIDTH         = 4096,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NWORDS        = WIDTH / DATA_WIDTH,
  parameter int unsigned COMPLETE_CODE = 9,
  parameter int unsigned READ_LAT      = 1,
  parameter int unsigned TIMEOUT       = 2**24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      message,
  input  logic [WIDTH-1:0]      exponent,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [WIDTH-1:0]      r_val,
  input  logic [WIDTH-1:0]      t_val,
  input  logic [63:0]           nprime0_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WIDTH-1:0]      result,
  modexp_io_sequencer_if.master mx
);

  localparam int unsigned CntW = $clog2(NWORDS + READ_LAT) + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StRead, StFinish} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            err_q, err_d;
  logic [WIDTH-1:0] m_q, e_q, n_q, r_q, t_q, res_q;
  logic [63:0]     np_q;
  logic            latch;
  logic            capture;
  logic [CntW-1:0] rd_idx;

  assign rd_idx     = cnt_q - CntW'(READ_LAT);
  assign result     = res_q;
  assign mx.nprime0 = np_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    to_d            = to_q;
    err_d           = err_q;
    latch           = 1'b0;
    capture         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    mx.startInput   = 1'b0;
    mx.startCompute = 1'b0;
    mx.getResult    = 1'b0;
    mx.m_buf        = '0;
    mx.e_buf        = '0;
    mx.n_buf        = '0;
    mx.r_buf        = '0;
    mx.t_buf        = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        busy          = 1'b1;
        mx.startInput = 1'b1;
        mx.m_buf      = m_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        mx.e_buf      = e_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        mx.n_buf      = n_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        mx.r_buf      = r_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        mx.t_buf      = t_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
        if (cnt_q == CntW'(NWORDS - 1)) begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        busy            = 1'b1;
        mx.startCompute = 1'b1;
        mx.getResult    = 1'b1;
        // Completion wins over a timeout landing on the same cycle.
        if (mx.exp_state == 5'(COMPLETE_CODE)) begin
          cnt_d   = '0;
          state_d = StRead;
        end else if (to_q == ToW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StRead: begin
        busy            = 1'b1;
        mx.startCompute = 1'b1;
        mx.getResult    = 1'b1;
        capture         = (cnt_q >= CntW'(READ_LAT));
        if (cnt_q == CntW'(READ_LAT + NWORDS - 1)) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        done    = 1'b1;
        error   = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      np_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
      if (latch) begin
        m_q  <= message;
        e_q  <= exponent;
        n_q  <= modulus;
        r_q  <= r_val;
        t_q  <= t_val;
        np_q <= nprime0_in;
      end
      if (capture) begin
        res_q[int'(rd_idx) * DATA_WIDTH +: DATA_WIDTH] <= mx.res_out;
      end
    end
  end

endmodule
